// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: emits numbered packets of programmable length, count,
// inter-packet gap and last-beat keep, with full handshake compliance under backpressure.
module axis_pkt_gen #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8,
    parameter int USER_W = 1,
    parameter int LEN_W  = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [LEN_W-1:0]  cfg_num_pkts,
    input  logic [7:0]        cfg_gap,
    input  logic [KEEP_W-1:0] cfg_last_keep,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  pkt_cnt,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic [USER_W-1:0] m_axis_tuser
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

    state_t            state_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  num_reg;
    logic [LEN_W-1:0]  beat_idx_reg;
    logic [7:0]        gap_reg;
    logic [7:0]        gap_cnt_reg;
    logic [KEEP_W-1:0] keep_reg;
    logic [31:0]       seq_reg;

    logic              hs;
    logic [31:0]       seq_inc;
    logic [LEN_W-1:0]  pkt_inc;
    logic [LEN_W-1:0]  beat_inc;
    logic              run_ends;
    logic              next_is_last;
    logic              first_is_last;
    logic              start_one_beat;
    logic [KEEP_W-1:0] start_keep;

    assign hs             = m_axis_tvalid & m_axis_tready;
    assign seq_inc        = seq_reg + 32'd1;
    assign pkt_inc        = pkt_cnt + LEN_W'(1);
    assign beat_inc       = beat_idx_reg + LEN_W'(1);
    assign run_ends       = (pkt_inc == num_reg) | abort;
    assign next_is_last   = (beat_inc == len_reg - LEN_W'(1));
    assign first_is_last  = (len_reg == LEN_W'(1));
    assign start_one_beat = (cfg_len == LEN_W'(1));
    // A zero last-beat keep is shorthand for a full final beat.
    assign start_keep     = (cfg_last_keep == '0) ? KEEP_ALL : cfg_last_keep;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            num_reg       <= '0;
            beat_idx_reg  <= '0;
            gap_reg       <= '0;
            gap_cnt_reg   <= '0;
            keep_reg      <= '0;
            seq_reg       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pkt_cnt       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        pkt_cnt <= '0;
                        if (cfg_len != '0 && cfg_num_pkts != '0) begin
                            len_reg       <= cfg_len;
                            num_reg       <= cfg_num_pkts;
                            gap_reg       <= cfg_gap;
                            keep_reg      <= start_keep;
                            beat_idx_reg  <= '0;
                            seq_reg       <= '0;
                            busy          <= 1'b1;
                            state_reg     <= SEND;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= '0;
                            m_axis_tuser  <= USER_W'(1'b1);
                            m_axis_tlast  <= start_one_beat;
                            m_axis_tkeep  <= start_one_beat ? start_keep : KEEP_ALL;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (hs) begin
                        seq_reg <= seq_inc;
                        if (m_axis_tlast) begin
                            pkt_cnt      <= pkt_inc;
                            beat_idx_reg <= '0;
                            if (run_ends) begin
                                state_reg     <= IDLE;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tdata  <= '0;
                                m_axis_tkeep  <= '0;
                                m_axis_tlast  <= 1'b0;
                                m_axis_tuser  <= '0;
                            end else if (gap_reg == 8'd0) begin
                                m_axis_tdata <= DATA_W'(seq_inc);
                                m_axis_tuser <= USER_W'(1'b1);
                                m_axis_tlast <= first_is_last;
                                m_axis_tkeep <= first_is_last ? keep_reg : KEEP_ALL;
                            end else begin
                                state_reg     <= GAP;
                                gap_cnt_reg   <= gap_reg;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tdata  <= '0;
                                m_axis_tkeep  <= '0;
                                m_axis_tlast  <= 1'b0;
                                m_axis_tuser  <= '0;
                            end
                        end else begin
                            beat_idx_reg <= beat_inc;
                            m_axis_tdata <= DATA_W'(seq_inc);
                            m_axis_tuser <= '0;
                            m_axis_tlast <= next_is_last;
                            m_axis_tkeep <= next_is_last ? keep_reg : KEEP_ALL;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (gap_cnt_reg == 8'd1) begin
                        // Counter value 1 marks the last idle cycle; the next cycle shows beat 0.
                        state_reg     <= SEND;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= DATA_W'(seq_reg);
                        m_axis_tuser  <= USER_W'(1'b1);
                        m_axis_tlast  <= first_is_last;
                        m_axis_tkeep  <= first_is_last ? keep_reg : KEEP_ALL;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

AXI4-Stream packet generator that drives a stream FIFO's slave port (or any AXIS sink) with deterministic, self-describing traffic. Software or a bench programs the packet length, packet count, inter-packet gap and last-beat keep, then pulses `start`. The block emits the packets with full AXIS handshake compliance under arbitrary backpressure. It is the traffic source paired with the team's AXIS FIFO for loopback, throughput and backpressure testing.

## Interface
- `DATA_W`, 32, tdata width in bits (multiple of 8, ≥ 32)
- `KEEP_W`, `DATA_W/8`, tkeep width
- `USER_W`, 1, tuser width (≥ 1)
- `LEN_W`, 16, width of length/count configuration and counters

- `aclk`  in  1  single clock; all logic on its rising edge
- `aresetn`  in  1  asynchronous, active-low reset
- `start`  in  1  1-cycle pulse; begins a run when idle, ignored while `busy`
- `abort`  in  1  level; ends the run after the current packet's tlast
- `cfg_len`  in  LEN_W  beats per packet; latched at start
- `cfg_num_pkts`  in  LEN_W  packets per run; latched at start
- `cfg_gap`  in  8  idle cycles between packets; latched at start
- `cfg_last_keep`  in  KEEP_W  tkeep on the last beat; 0 means all ones; latched at start
- `busy`  out  1  high from the cycle after an accepted start until the run ends
- `done`  out  1  1-cycle pulse at the end of a run
- `pkt_cnt`  out  LEN_W  packets completed in the current or last run
- `m_axis_tvalid`  out  1  AXIS valid
- `m_axis_tready`  in  1  AXIS ready
- `m_axis_tdata`  out  DATA_W  beat sequence number
- `m_axis_tkeep`  out  KEEP_W  byte enables
- `m_axis_tlast`  out  1  last beat of packet
- `m_axis_tuser`  out  USER_W  bit 0 = first beat of packet; upper bits 0

## Operation
- **States:** IDLE, SEND, GAP.
- **IDLE:**
  - Outputs: tvalid=0, busy=0.
  - `start` with `cfg_len`≠0 and `cfg_num_pkts`≠0: latch config, clear `pkt_cnt`, clear beat index and sequence counter, go to SEND.
  - `start` with either config field 0: pulse `done` next cycle, `pkt_cnt`=0, stay IDLE.
- **SEND:**
  - Outputs: tvalid=1.
  - tdata = 32-bit sequence counter, zero-extended to DATA_W. It starts at 0 and increments on every handshake; it does not restart per packet.
  - tuser[0]=1 only when beat index = 0.
  - tlast=1 when beat index = len−1.
  - tkeep = all ones, except on the tlast beat, where it is the latched `cfg_last_keep` (all ones if that value was 0).
- **Handshake** (tvalid & tready):
  - Advance beat index and sequence counter.
  - On a tlast handshake, `pkt_cnt`+1 and the beat index resets to 0.
- **After a tlast handshake:**
  - If `pkt_cnt`+1 = num_pkts, or `abort` is high: go to IDLE and pulse `done`.
  - Otherwise, if gap=0: stay in SEND; the next packet's first beat follows immediately.
  - Otherwise: go to GAP with the gap counter loaded to `cfg_gap`.
- **GAP:** tvalid=0. Decrement the counter each cycle; go to SEND when it expires, giving exactly `cfg_gap` low cycles. If `abort` is high in GAP, go to IDLE and pulse `done` next cycle.
- **AXIS rules:**
  - Once tvalid is high, it and all payload signals hold stable until the handshake.
  - `abort` never truncates a packet.
  - tvalid never depends combinationally on tready.
- **Counter width:** `pkt_cnt` and the beat index are LEN_W bits. `cfg_len` = 2^LEN_W−1 is the maximum supported; no wrap occurs within a packet.
- **Start while busy:** ignored; config inputs may change freely while busy.

## Timing
- **Reset:** all outputs 0 (tvalid, tdata, tkeep, tlast, tuser, busy, done, pkt_cnt); state IDLE. The assertion takes effect immediately; the deassertion is used synchronously. Reset mid-packet drops tvalid immediately; this is the only permitted tvalid drop.
- **Start latency:** `start` sampled in cycle N gives tvalid=1 and busy=1 in cycle N+1, presenting beat 0.
- **Throughput:** all outputs are registered; 1 beat/cycle with tready held high.
- **Packet spacing:** exactly `cfg_gap` tvalid-low cycles between a tlast handshake and the next first beat.
- **Run end:** `done` is high for exactly the cycle after the final tlast handshake (or the abort exit from GAP). busy falls in that same cycle, and `pkt_cnt` is final in that cycle.

## Test plan
- **Basic run:** len=4, num=2, gap=0, keep=0, tready=1 → 8 back-to-back beats, tdata 0..7; tlast on beats 3 and 7; tuser[0] on 0 and 4; tkeep=0xF; `done` one cycle after beat 7; `pkt_cnt`=2.
- **Gap and last keep:** len=3, num=3, gap=5, keep=0x3 → exactly 5 idle cycles between packets; tkeep=0x3 only on tlast beats; total 9 beats.
- **Random backpressure:** random tready at 50%, len=17, num=20 → payload stable while tvalid&!tready; 340 beats in order, tdata 0..339; no tvalid drop.
- **Abort:** abort asserted on beat 2 of packet 1 (len=8, num=10) → packet 1 completes to tlast; `done` pulses; `pkt_cnt`=2. Abort during GAP → no further tvalid; `done` next cycle.
- **Degenerate config:** start with len=0 → `done` pulse next cycle, no tvalid, `pkt_cnt`=0. A second start while busy → ignored; run count unchanged.
- **Reset mid-packet:** aresetn low during beat 5 → all outputs 0 immediately; after release, a new start restarts tdata at 0.
